// File: rtl/regfile_write_arbiter_if.sv
// Write-back, multi-cycle result, decode lookup and register-file write signals of the arbiter.
// The master side drives requests; the slave side (the arbiter) drives grants and lookups.
interface regfile_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_wn;
  logic [31:0] wb_d;
  logic        mc_issue;
  logic [4:0]  mc_issue_wn;
  logic        mc_valid;
  logic [4:0]  mc_wn;
  logic [31:0] mc_d;
  logic        mc_ready;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic        stall_a;
  logic        stall_b;
  logic        fwd_a_hit;
  logic [31:0] fwd_a_d;
  logic        fwd_b_hit;
  logic [31:0] fwd_b_d;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;
  logic [3:0]  fifo_cnt;

  modport master (
    output wb_we, wb_wn, wb_d, mc_issue, mc_issue_wn, mc_valid, mc_wn, mc_d, rna, rnb,
    input  mc_ready, stall_a, stall_b, fwd_a_hit, fwd_a_d, fwd_b_hit, fwd_b_d,
    input  rf_we, rf_wn, rf_d, fifo_cnt
  );

  modport slave (
    input  wb_we, wb_wn, wb_d, mc_issue, mc_issue_wn, mc_valid, mc_wn, mc_d, rna, rnb,
    output mc_ready, stall_a, stall_b, fwd_a_hit, fwd_a_d, fwd_b_hit, fwd_b_d,
    output rf_we, rf_wn, rf_d, fifo_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB wins, multi-cycle results cut through (0 cycles) or queue (>=1 cycle),
// mc_ready drops only when the queue is full with no pop. Define RFARB_BYPASS_EN to forward queued data to decode.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input logic                    clk,
  input logic                    clrn,
  regfile_write_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH4 = 4'(FIFO_DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [4:0]            wn_q [FIFO_DEPTH];
  logic [31:0]           d_q  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q, live_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  ptr_t                  wr_ptr_q, wr_ptr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           busy_q, busy_d;

  logic                  wb_wr;
  logic                  empty, full;
  logic [4:0]            head_wn;
  logic [31:0]           head_d;
  logic                  head_live, head_dead;
  logic                  sel_head, fifo_idle, cut;
  logic                  pop, accept, push, push_drop;
  logic [FIFO_DEPTH-1:0] kill_vec;
  logic                  hit_a, hit_b;
  logic [31:0]           fwd_a, fwd_b;

  assign wb_wr     = bus.wb_we && (bus.wb_wn != 5'd0);
  assign empty     = (cnt_q == 4'd0);
  assign full      = (cnt_q == DEPTH4);
  assign head_wn   = wn_q[rd_ptr_q];
  assign head_d    = d_q[rd_ptr_q];
  assign head_live = !empty && live_q[rd_ptr_q];
  assign head_dead = !empty && !live_q[rd_ptr_q];
  assign sel_head  = !wb_wr && head_live;

  // A lone dead head vanishes this cycle, so a fresh result may cut through alongside its pop.
  assign fifo_idle = empty || ((cnt_q == 4'd1) && head_dead);
  assign cut       = !wb_wr && fifo_idle && bus.mc_valid && (bus.mc_wn != 5'd0);
  assign pop       = sel_head || head_dead;

  assign bus.mc_ready = !full || pop;
  assign accept       = bus.mc_valid && bus.mc_ready;
  assign push_drop    = accept && (bus.mc_wn != 5'd0) && !cut && wb_wr && (bus.mc_wn == bus.wb_wn);
  assign push         = accept && (bus.mc_wn != 5'd0) && !cut && !push_drop;

  always_comb begin
    kill_vec = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      kill_vec[i] = wb_wr && live_q[i] && (wn_q[i] == bus.wb_wn);
    end
  end

  always_comb begin
    live_d   = live_q & ~kill_vec;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + ptr_t'(1);
    end
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + ptr_t'(1);
    end
    cnt_d = cnt_q + {3'b000, push} - {3'b000, pop};
  end

  // Set is applied last so a same-cycle issue to a just-completed register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (sel_head) busy_d[head_wn] = 1'b0;
    if (cut || push_drop) busy_d[bus.mc_wn] = 1'b0;
    if (|kill_vec) busy_d[bus.wb_wn] = 1'b0;
    if (bus.mc_issue && (bus.mc_issue_wn != 5'd0)) busy_d[bus.mc_issue_wn] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        wn_q[i] <= '0;
        d_q[i]  <= '0;
      end
    end else begin
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      if (push) begin
        wn_q[wr_ptr_q] <= bus.mc_wn;
        d_q[wr_ptr_q]  <= bus.mc_d;
      end
    end
  end

  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wn = 5'd0;
    bus.rf_d  = 32'd0;
    if (clrn) begin
      if (wb_wr) begin
        bus.rf_we = 1'b1;
        bus.rf_wn = bus.wb_wn;
        bus.rf_d  = bus.wb_d;
      end else if (sel_head) begin
        bus.rf_we = 1'b1;
        bus.rf_wn = head_wn;
        bus.rf_d  = head_d;
      end else if (cut) begin
        bus.rf_we = 1'b1;
        bus.rf_wn = bus.mc_wn;
        bus.rf_d  = bus.mc_d;
      end
    end
  end

`ifdef RFARB_BYPASS_EN
  // Scan oldest to youngest so the last match is the youngest; the head being written is excluded.
  always_comb begin
    ptr_t idx;
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = 32'd0;
    fwd_b = 32'd0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      idx = rd_ptr_q + ptr_t'(k);
      if ((k < int'(cnt_q)) && live_q[idx] && !((k == 0) && sel_head)) begin
        if ((bus.rna != 5'd0) && (wn_q[idx] == bus.rna)) begin
          hit_a = 1'b1;
          fwd_a = d_q[idx];
        end
        if ((bus.rnb != 5'd0) && (wn_q[idx] == bus.rnb)) begin
          hit_b = 1'b1;
          fwd_b = d_q[idx];
        end
      end
    end
  end
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
  assign fwd_a = 32'd0;
  assign fwd_b = 32'd0;
`endif

  assign bus.fwd_a_hit = hit_a;
  assign bus.fwd_a_d   = fwd_a;
  assign bus.fwd_b_hit = hit_b;
  assign bus.fwd_b_d   = fwd_b;
  assign bus.stall_a   = (bus.rna != 5'd0) && busy_q[bus.rna] && !hit_a;
  assign bus.stall_b   = (bus.rnb != 5'd0) && busy_q[bus.rnb] && !hit_b;
  assign bus.fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter (FIFO_DEPTH=2); inputs change after rising edges, outputs are checked on falling edges.
module tb_regfile_write_arbiter;

  logic clk;
  logic clrn;
  int   checks;
  int   failures;

  regfile_write_arbiter_if bus_if ();

  regfile_write_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_wn;
    logic [31:0] wb_d;
    logic        iss;
    logic [4:0]  iss_wn;
    logic        mv;
    logic [4:0]  mwn;
    logic [31:0] md;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic        e_we;
    logic [4:0]  e_wn;
    logic [31:0] e_d;
    logic        e_rdy;
    logic        e_sa;
    logic        e_sb;
    logic [3:0]  e_cnt;
  } vec_t;

  function automatic vec_t v(
    input logic a_we, input logic [4:0] a_wn, input logic [31:0] a_d,
    input logic a_iss, input logic [4:0] a_iwn,
    input logic a_mv, input logic [4:0] a_mwn, input logic [31:0] a_md,
    input logic [4:0] a_rna, input logic [4:0] a_rnb,
    input logic x_we, input logic [4:0] x_wn, input logic [31:0] x_d,
    input logic x_rdy, input logic x_sa, input logic x_sb, input logic [3:0] x_cnt);
    vec_t t;
    t.wb_we = a_we;  t.wb_wn = a_wn;   t.wb_d = a_d;
    t.iss   = a_iss; t.iss_wn = a_iwn;
    t.mv    = a_mv;  t.mwn = a_mwn;    t.md = a_md;
    t.rna   = a_rna; t.rnb = a_rnb;
    t.e_we  = x_we;  t.e_wn = x_wn;    t.e_d = x_d;
    t.e_rdy = x_rdy; t.e_sa = x_sa;    t.e_sb = x_sb; t.e_cnt = x_cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    bus_if.wb_we       = t.wb_we;
    bus_if.wb_wn       = t.wb_wn;
    bus_if.wb_d        = t.wb_d;
    bus_if.mc_issue    = t.iss;
    bus_if.mc_issue_wn = t.iss_wn;
    bus_if.mc_valid    = t.mv;
    bus_if.mc_wn       = t.mwn;
    bus_if.mc_d        = t.md;
    bus_if.rna         = t.rna;
    bus_if.rnb         = t.rnb;
  endtask

  task automatic step(input vec_t t, input string tag);
    @(posedge clk);
    #1;
    apply(t);
    @(negedge clk);
    chk({tag, " rf_we"}, {31'd0, bus_if.rf_we}, {31'd0, t.e_we});
    if (t.e_we) begin
      chk({tag, " rf_wn"}, {27'd0, bus_if.rf_wn}, {27'd0, t.e_wn});
      chk({tag, " rf_d"}, bus_if.rf_d, t.e_d);
    end
    chk({tag, " mc_ready"}, {31'd0, bus_if.mc_ready}, {31'd0, t.e_rdy});
    chk({tag, " stall_a"}, {31'd0, bus_if.stall_a}, {31'd0, t.e_sa});
    chk({tag, " stall_b"}, {31'd0, bus_if.stall_b}, {31'd0, t.e_sb});
    chk({tag, " fifo_cnt"}, {28'd0, bus_if.fifo_cnt}, {28'd0, t.e_cnt});
  endtask

  vec_t tbl[23];
  vec_t idle;
  logic bypass;

  initial begin
    checks   = 0;
    failures = 0;
`ifdef RFARB_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif

    //        wb_we wn d        iss wn  mv wn d            rna rnb  we wn d            rdy sa sb cnt
    tbl[0]  = v(0, 0,  0,       1, 9,   0, 0,  0,           9, 0,   0, 0, 0,           1, 0, 0, 0);
    tbl[1]  = v(0, 0,  0,       0, 0,   0, 0,  0,           9, 0,   0, 0, 0,           1, 1, 0, 0);
    tbl[2]  = v(0, 0,  0,       0, 0,   1, 9,  32'hDEADBEEF, 9, 0,  1, 9, 32'hDEADBEEF, 1, 1, 0, 0);
    tbl[3]  = v(0, 0,  0,       0, 0,   0, 0,  0,           9, 0,   0, 0, 0,           1, 0, 0, 0);
    tbl[4]  = v(0, 0,  0,       1, 5,   0, 0,  0,           0, 0,   0, 0, 0,           1, 0, 0, 0);
    tbl[5]  = v(0, 0,  0,       1, 6,   0, 0,  0,           0, 0,   0, 0, 0,           1, 0, 0, 0);
    tbl[6]  = v(0, 0,  0,       1, 7,   0, 0,  0,           0, 5,   0, 0, 0,           1, 0, 1, 0);
    tbl[7]  = v(1, 1,  32'hA1,  0, 0,   1, 5,  5,           0, 5,   1, 1, 32'hA1,      1, 0, 1, 0);
    tbl[8]  = v(1, 2,  32'hA2,  0, 0,   1, 6,  6,           0, 0,   1, 2, 32'hA2,      1, 0, 0, 1);
    tbl[9]  = v(1, 3,  32'hA3,  0, 0,   1, 7,  7,           0, 0,   1, 3, 32'hA3,      0, 0, 0, 2);
    tbl[10] = v(1, 4,  32'hA4,  0, 0,   1, 7,  7,           0, 0,   1, 4, 32'hA4,      0, 0, 0, 2);
    tbl[11] = v(0, 0,  0,       0, 0,   1, 7,  7,           0, 5,   1, 5, 5,           1, 0, 1, 2);
    tbl[12] = v(0, 0,  0,       0, 0,   0, 0,  0,           0, 5,   1, 6, 6,           1, 0, 0, 2);
    tbl[13] = v(0, 0,  0,       0, 0,   0, 0,  0,           0, 0,   1, 7, 7,           1, 0, 0, 1);
    tbl[14] = v(0, 0,  0,       0, 0,   0, 0,  0,           7, 0,   0, 0, 0,           1, 0, 0, 0);
    tbl[15] = v(0, 0,  0,       1, 10,  0, 0,  0,           0, 0,   0, 0, 0,           1, 0, 0, 0);
    tbl[16] = v(1, 1,  32'hB1,  0, 0,   1, 10, 32'h11,      10, 0,  1, 1, 32'hB1,      1, 1, 0, 0);
    tbl[17] = v(1, 10, 32'h22,  0, 0,   0, 0,  0,           0, 0,   1, 10, 32'h22,     1, 0, 0, 1);
    tbl[18] = v(0, 0,  0,       0, 0,   0, 0,  0,           10, 0,  0, 0, 0,           1, 0, 0, 1);
    tbl[19] = v(0, 0,  0,       0, 0,   0, 0,  0,           10, 0,  0, 0, 0,           1, 0, 0, 0);
    tbl[20] = v(1, 0,  32'h77,  0, 0,   1, 11, 32'h33,      0, 0,   1, 11, 32'h33,     1, 0, 0, 0);
    tbl[21] = v(0, 0,  0,       0, 0,   1, 0,  32'h44,      0, 0,   0, 0, 0,           1, 0, 0, 0);
    tbl[22] = v(0, 0,  0,       0, 0,   0, 0,  0,           0, 0,   0, 0, 0,           1, 0, 0, 0);
    idle    = v(0, 0,  0,       0, 0,   0, 0,  0,           0, 0,   0, 0, 0,           1, 0, 0, 0);

    // Reset with a WB write held: the write port stays off.
    clrn = 1'b0;
    apply(v(1, 3, 32'h33, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 1, 0, 0, 0));
    #2;
    chk("reset rf_we", {31'd0, bus_if.rf_we}, 32'd0);
    chk("reset fifo_cnt", {28'd0, bus_if.fifo_cnt}, 32'd0);
    chk("reset stall_a", {31'd0, bus_if.stall_a}, 32'd0);
    chk("reset fwd_a_hit", {31'd0, bus_if.fwd_a_hit}, 32'd0);
    chk("reset fwd_a_d", bus_if.fwd_a_d, 32'd0);
    #10;
    apply(idle);
    clrn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Fill, drain and refill the two-entry queue three times.
    for (int r = 0; r < 3; r++) begin
      logic [4:0]  wa, wb;
      logic [31:0] da, db;
      wa = 5'(16 + 2 * r);
      wb = 5'(17 + 2 * r);
      da = 32'h100 * r + 32'(wa);
      db = 32'h100 * r + 32'(wb);
      step(v(1, 1, 32'hC0, 0, 0, 1, wa, da, 0, 0, 1, 1, 32'hC0, 1, 0, 0, 0), $sformatf("wrap%0d fillA", r));
      step(v(1, 2, 32'hC1, 0, 0, 1, wb, db, 0, 0, 1, 2, 32'hC1, 1, 0, 0, 1), $sformatf("wrap%0d fillB", r));
      step(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, wa, da, 1, 0, 0, 2), $sformatf("wrap%0d drainA", r));
      step(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, wb, db, 1, 0, 0, 1), $sformatf("wrap%0d drainB", r));
      step(idle, $sformatf("wrap%0d empty", r));
    end

    // r12 queued behind WB traffic: forwarded when bypass is built in, otherwise decode stalls.
    step(v(0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "byp issue");
    step(v(1, 1, 32'hD1, 0, 0, 1, 12, 32'h55, 0, 0, 1, 1, 32'hD1, 1, 0, 0, 0), "byp push");
    step(v(1, 2, 32'hD2, 0, 0, 0, 0, 0, 12, 0, 1, 2, 32'hD2, 1, !bypass, 0, 1), "byp queued");
    chk("byp fwd_a_hit", {31'd0, bus_if.fwd_a_hit}, {31'd0, bypass});
    chk("byp fwd_a_d", bus_if.fwd_a_d, bypass ? 32'h55 : 32'h0);
    step(v(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 1, 12, 32'h55, 1, 1, 0, 1), "byp written");
    chk("byp written fwd_a_hit", {31'd0, bus_if.fwd_a_hit}, 32'd0);
    step(v(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 1, 0, 0, 0), "byp done");

    // Reset while a result is queued and its register is busy.
    step(v(0, 0, 0, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "rst issue");
    step(v(1, 1, 32'hE1, 0, 0, 1, 20, 32'h66, 0, 0, 1, 1, 32'hE1, 1, 0, 0, 0), "rst push");
    @(posedge clk);
    #1;
    apply(v(1, 3, 32'h33, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("midrst fifo_cnt before", {28'd0, bus_if.fifo_cnt}, 32'd1);
    clrn = 1'b0;
    #1;
    chk("midrst rf_we", {31'd0, bus_if.rf_we}, 32'd0);
    chk("midrst fifo_cnt", {28'd0, bus_if.fifo_cnt}, 32'd0);
    chk("midrst stall_a", {31'd0, bus_if.stall_a}, 32'd0);
    #1;
    clrn = 1'b1;
    apply(idle);
    step(v(0, 0, 0, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 1, 0, 0, 0), "after rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
